sramlike_arbiter: RTL

SRAMLIKE_ARBITER -- requirements
Module: sramlike_arbiter

---
 rtl/sramlike_arbiter_pkg.sv | 17 +
 rtl/sramlike_arbiter.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/sramlike_arbiter_pkg.sv
// rtl/sramlike_arbiter_pkg.sv - shared state/owner encodings for the sram-like arbiter
package sramlike_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_e;

  localparam int                  STARVE_W   = 3;
  localparam logic [STARVE_W-1:0] STARVE_MAX = '1;

endpackage

// File: rtl/sramlike_arbiter.sv
// rtl/sramlike_arbiter.sv - 2:1 sram-like arbiter, inst/data slaves onto one master
// Request path is combinational; only FSM state, owner and starvation count are registered.
module sramlike_arbiter
  import sramlike_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic [31:0] inst_rdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic        m_req,
  output logic        m_wr,
  output logic [1:0]  m_size,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_addr_ok,
  input  logic        m_data_ok
);

  state_e              state_q, state_d;
  owner_e              owner_q, owner_d;
  logic [STARVE_W-1:0] starve_q, starve_d;

  logic   starve_ok;
  logic   grant_vld;
  owner_e grant_sel;
  logic   addr_hs;
  logic   ok_vld;
  owner_e ok_sel;

  assign starve_ok = (32'(starve_q) < STARVE_LIMIT);

  // Grants are suppressed while in reset so nothing leaks to the master.
  always_comb begin
    grant_vld = 1'b0;
    grant_sel = OWN_INST;
    if (rst && (state_q == ST_IDLE)) begin
      if (data_req && starve_ok) begin
        grant_vld = 1'b1;
        grant_sel = OWN_DATA;
      end else if (inst_req) begin
        grant_vld = 1'b1;
        grant_sel = OWN_INST;
      end else if (data_req) begin
        grant_vld = 1'b1;
        grant_sel = OWN_DATA;
      end
    end
  end

  always_comb begin
    m_req   = 1'b0;
    m_wr    = 1'b0;
    m_size  = 2'd0;
    m_addr  = 32'd0;
    m_wdata = 32'd0;
    if (grant_vld) begin
      m_req = 1'b1;
      if (grant_sel == OWN_DATA) begin
        m_wr    = data_wr;
        m_size  = data_size;
        m_addr  = data_addr;
        m_wdata = data_wdata;
      end else begin
        m_wr    = inst_wr;
        m_size  = inst_size;
        m_addr  = inst_addr;
        m_wdata = inst_wdata;
      end
    end
  end

  assign addr_hs      = grant_vld & m_addr_ok;
  assign inst_addr_ok = addr_hs & (grant_sel == OWN_INST);
  assign data_addr_ok = addr_hs & (grant_sel == OWN_DATA);

  // A data_ok in IDLE only counts when it coincides with an address handshake.
  always_comb begin
    ok_vld = 1'b0;
    ok_sel = OWN_INST;
    if (rst) begin
      if (state_q == ST_BUSY) begin
        ok_vld = m_data_ok;
        ok_sel = owner_q;
      end else if (addr_hs && m_data_ok) begin
        ok_vld = 1'b1;
        ok_sel = grant_sel;
      end
    end
  end

  assign inst_data_ok = ok_vld & (ok_sel == OWN_INST);
  assign data_data_ok = ok_vld & (ok_sel == OWN_DATA);
  assign inst_rdata   = m_rdata;
  assign data_rdata   = m_rdata;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    starve_d = starve_q;
    case (state_q)
      ST_IDLE: begin
        if (addr_hs && !m_data_ok) begin
          state_d = ST_BUSY;
          owner_d = grant_sel;
        end
      end
      ST_BUSY: begin
        if (m_data_ok) begin
          state_d = ST_IDLE;
        end
      end
    endcase
    if (!inst_req) begin
      starve_d = '0;
    end else if (addr_hs) begin
      if (grant_sel == OWN_INST) begin
        starve_d = '0;
      end else if (starve_q != STARVE_MAX) begin
        starve_d = starve_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      owner_q  <= OWN_INST;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      starve_q <= starve_d;
    end
  end

endmodule
